xoodyak_host_ctrl: RTL
======================

XOODYAK_HOST_CTRL -- requirements
Module: xoodyak_host_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 req_valid / req_ready  input / output  1 / 1  hash-request handshake; transfer on both high.
REQ-004 req_len  input  12  message length in bytes, sampled on request transfer.
REQ-005 in_valid / in_ready / in_data  input / output / input  1 / 1 / 8  message byte stream; transfer on valid and ready both high.
REQ-006 core_start  output  1  one-cycle start pulse to the hash core.
REQ-007 core_msg / core_msg_len  output  8 / 12  byte presented to the core / latched req_len.
REQ-008 core_busy  input  1  low = core consumes core_msg at this edge (absorb phase only).
REQ-009 core_valid / core_hash / core_hash_len  input  1 / 8 / 8  hash byte strobe, byte, core byte index.
REQ-010 digest  output  256  collected hash; byte k at bits [8k+7:8k].
REQ-011 digest_valid  output  1  one-cycle pulse when all 32 bytes are captured.
REQ-012 err  output  1  sticky error flag; cleared only on the next request transfer or reset.

Function
REQ-013 FSM states: IDLE, PREFILL, ABSORB, SQUEEZE, DONE; encoding from the shared package.
REQ-014 IDLE: req_ready=1; on transfer latch req_len, clear err and byte counters, go to PREFILL.
REQ-015 PREFILL: in_ready=1 while FIFO not full and accepted < req_len; when FIFO count >= min(req_len,32), pulse core_start for one cycle, go to ABSORB.
REQ-016 req_len=0: core_start issued in the first PREFILL cycle; no bytes accepted.
REQ-017 ABSORB: on each cycle with core_busy low and fed < req_len, pop one FIFO byte onto core_msg; fed increments by 1.
REQ-018 Underrun: core_busy low, fed < req_len, FIFO empty -> core_msg=0x00, fed increments, err set.
REQ-019 in_ready stays 1 in ABSORB while FIFO not full and accepted < req_len; simultaneous push and pop leave count unchanged.
REQ-020 In any state, no byte is accepted once accepted == req_len; core_msg is 0x00 when not popping.
REQ-021 ABSORB -> SQUEEZE on the first core_valid; that byte is captured.
REQ-022 SQUEEZE: each core_valid writes core_hash into digest byte idx, idx increments (5-bit, 0..31).
REQ-023 After the byte at idx=31: digest_valid pulses the next cycle, go to DONE; DONE -> IDLE after one cycle.
REQ-024 digest holds its value until the next capture; core_valid in IDLE/PREFILL is ignored and sets err.
REQ-025 Counters accepted/fed are 12-bit, never wrap (max 4095).

Reset
REQ-026 On reset, all outputs are 0 (req_ready becomes 1 in the first cycle after release), FSM=IDLE, FIFO empty, counters 0.
REQ-027 Reset mid-operation aborts the hash immediately; no digest_valid is produced.

Configuration
REQ-028 Macro XOODYAK_HOST_LENCHK_EN: when defined, core_hash_len != idx on any core_valid sets err; when undefined, core_hash_len is unused and no check logic exists.

Structure
REQ-029 Package xoodyak_pkg: FSM state enum, DIGEST_BYTES=32, BLOCK_BYTES=16, FIFO_DEPTH=32.
REQ-030 One sub-module xoodyak_byte_fifo (32x8, synchronous, count output, async active-high reset).

Verification
REQ-031 req_len=5, bytes 01..05 back-to-back -> one core_start; core_msg 01..05 on busy-low cycles; no err.
REQ-032 req_len=40, upstream stalls every other cycle -> start after 32 buffered; underrun while the core absorbs block 3 -> err=1.
REQ-033 req_len=0 -> core_start in the first PREFILL cycle, in_ready never high; digest captured normally.
REQ-034 Core returns bytes 0x00..0x1F -> digest[7:0]=0x00, digest[255:248]=0x1F, single digest_valid pulse.
REQ-035 With XOODYAK_HOST_LENCHK_EN defined, core_hash_len skips 3->5 -> err=1; with it undefined -> err=0.
REQ-036 Reset asserted mid-SQUEEZE at idx=10 -> all outputs 0, no digest_valid; the next request completes cleanly.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// xoodyak_pkg: shared FSM encoding, sizing constants and prefill helper for the Xoodyak host controller
package xoodyak_pkg;

    localparam int DIGEST_BYTES = 32;
    localparam int BLOCK_BYTES  = 16;
    localparam int FIFO_DEPTH   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } state_e;

    // Number of buffered bytes needed before the core may start: the whole
    // message if it fits in the FIFO, otherwise a full FIFO.
    function automatic logic [11:0] prefill_target(input logic [11:0] len);
        return (len < 12'(FIFO_DEPTH)) ? len : 12'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/xoodyak_host_ctrl_if.sv
// xoodyak_host_ctrl_if: request, byte-stream, hash-core and digest signals of the host controller
// Ports: none (signal bundle only)
// Modports:
//   slave  - the controller: drives req_ready, in_ready, core_start, core_msg, core_msg_len, digest, digest_valid, err
//   master - the environment: drives req_valid, req_len, in_valid, in_data, core_busy, core_valid, core_hash, core_hash_len
interface xoodyak_host_ctrl_if;

    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_len;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         core_start;
    logic [7:0]   core_msg;
    logic [11:0]  core_msg_len;
    logic         core_busy;
    logic         core_valid;
    logic [7:0]   core_hash;
    logic [7:0]   core_hash_len;
    logic [255:0] digest;
    logic         digest_valid;
    logic         err;

    modport slave (
        input  req_valid, req_len, in_valid, in_data, core_busy, core_valid, core_hash, core_hash_len,
        output req_ready, in_ready, core_start, core_msg, core_msg_len, digest, digest_valid, err
    );

    modport master (
        output req_valid, req_len, in_valid, in_data, core_busy, core_valid, core_hash, core_hash_len,
        input  req_ready, in_ready, core_start, core_msg, core_msg_len, digest, digest_valid, err
    );

endinterface

// File: rtl/xoodyak_byte_fifo.sv
// xoodyak_byte_fifo: 32x8 synchronous byte FIFO with occupancy count
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   flush_i           - empty the FIFO (pointers and count to zero)
//   push_i, wdata_i   - write one byte (ignored when full)
//   pop_i, rdata_o    - head byte is always visible on rdata_o; pop_i removes it (ignored when empty)
//   count_o, full_o, empty_o - occupancy status
module xoodyak_byte_fifo
    import xoodyak_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic [5:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [FIFO_DEPTH];
    logic [4:0] wr_q;
    logic [4:0] rd_q;
    logic [5:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = cnt_q == 6'(FIFO_DEPTH);
    assign empty_o = cnt_q == 6'd0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + 5'(do_push);
            rd_q  <= rd_q + 5'(do_pop);
            cnt_q <= cnt_q + 6'(do_push) - 6'(do_pop);
        end
    end

endmodule

// File: rtl/xoodyak_host_ctrl.sv
// xoodyak_host_ctrl: buffers a message for a Xoodyak hash core, feeds it bytewise and collects the 32-byte digest
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - xoodyak_host_ctrl_if.slave: request handshake, message byte stream,
//                core start/feed/hash-return signals, digest, digest_valid pulse, sticky err
// Option: define XOODYAK_HOST_LENCHK_EN to flag err when core_hash_len disagrees with the capture index.
module xoodyak_host_ctrl
    import xoodyak_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    xoodyak_host_ctrl_if.slave bus
);

    state_e       state_q, state_d;
    logic [11:0]  len_q, len_d;
    logic [11:0]  acc_q, acc_d;
    logic [11:0]  fed_q, fed_d;
    logic [4:0]   idx_q, idx_d;
    logic [255:0] digest_q, digest_d;
    logic         dv_q, dv_d;
    logic         err_q, err_d;
    logic         rdy_en_q;
    logic [7:0]   fifo_rdata;
    logic [5:0]   fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         req_xfer;
    logic         push;
    logic         start;
    logic         feed;
    logic         pop;
    logic         capture;
    logic         last;
    logic         stray;
    logic         len_err;

    // rdy_en_q keeps req_ready low until the first edge after reset release.
    assign bus.req_ready    = (state_q == S_IDLE) && rdy_en_q;
    assign bus.in_ready     = (state_q == S_PREFILL || state_q == S_ABSORB) && !fifo_full && (acc_q < len_q);
    assign bus.core_start   = start;
    assign bus.core_msg     = pop ? fifo_rdata : 8'h00;
    assign bus.core_msg_len = len_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = dv_q;
    assign bus.err          = err_q;

    assign req_xfer = bus.req_valid && bus.req_ready;
    assign push     = bus.in_valid && bus.in_ready;
    assign start    = (state_q == S_PREFILL) && ({6'd0, fifo_count} >= prefill_target(len_q));
    assign feed     = (state_q == S_ABSORB) && !bus.core_busy && (fed_q < len_q);
    // A feed with an empty FIFO is an underrun: core_msg reads 0x00 and fed still advances.
    assign pop      = feed && !fifo_empty;
    assign capture  = bus.core_valid && (state_q == S_ABSORB || state_q == S_SQUEEZE);
    assign last     = idx_q == 5'(DIGEST_BYTES - 1);
    assign stray    = bus.core_valid && (state_q == S_IDLE || state_q == S_PREFILL);

`ifdef XOODYAK_HOST_LENCHK_EN
    assign len_err = bus.core_valid && (bus.core_hash_len != {3'b000, idx_q});
`else
    assign len_err = 1'b0;
`endif

    xoodyak_byte_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (req_xfer),
        .push_i  (push),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = push ? acc_q + 12'd1 : acc_q;
        fed_d    = feed ? fed_q + 12'd1 : fed_q;
        idx_d    = capture ? idx_q + 5'd1 : idx_q;
        digest_d = digest_q;
        if (capture) digest_d[{idx_q, 3'b000} +: 8] = bus.core_hash;
        dv_d     = capture && last;
        // A new request clears err, but an error raised in the same cycle still sticks.
        err_d    = (req_xfer ? 1'b0 : err_q) | (feed && fifo_empty) | stray | len_err;
        case (state_q)
            S_IDLE: begin
                if (req_xfer) begin
                    state_d = S_PREFILL;
                    len_d   = bus.req_len;
                    acc_d   = '0;
                    fed_d   = '0;
                    idx_d   = '0;
                end
            end
            S_PREFILL: state_d = start ? S_ABSORB : S_PREFILL;
            S_ABSORB:  state_d = capture ? (last ? S_DONE : S_SQUEEZE) : S_ABSORB;
            S_SQUEEZE: state_d = (capture && last) ? S_DONE : S_SQUEEZE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            fed_q    <= '0;
            idx_q    <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            fed_q    <= fed_d;
            idx_q    <= idx_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
